// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with debounce; accepted keys shift into an 8-digit display register.
// Latency: key_valid one clock after the scan end that completes DEBOUNCE_SCANS identical scans.
// Backpressure: none; strobes are fire-and-forget, digits update on the clock after key_valid.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [31:0] digits,
  output logic [3:0]  digit_count
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, HELD} state_t;

  state_t           state, state_nxt;
  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic             scan_hit, prev_hit;
  logic [3:0]       scan_code, prev_code;
  logic [CNT_W-1:0] stable_cnt, cnt_nxt;

  logic       sample, scan_end, col_hit, res_hit, same, stable_now;
  logic       accept, release_key;
  logic [1:0] first_row;
  logic [3:0] col_code, res_code;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign col = ~(4'b0001 << col_idx);

  always_comb begin
    first_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) first_row = 2'(r);
    end
  end

  assign sample   = (div_cnt == DIV_LAST);
  assign scan_end = sample && (col_idx == 2'd3);
  assign col_hit  = (row_sync != 4'hF);
  assign col_code = key_map(first_row, col_idx);
  // Earlier columns win, so a hit already latched this scan masks the current column.
  assign res_hit  = scan_hit | col_hit;
  assign res_code = scan_hit ? scan_code : (col_hit ? col_code : 4'h0);
  assign same     = (res_hit == prev_hit) && (!res_hit || res_code == prev_code);
  assign cnt_nxt  = !same ? CNT_W'(1) : (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1);
  assign stable_now = (cnt_nxt == CNT_MAX);

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    release_key = 1'b0;
    case (state)
      IDLE: if (scan_end && stable_now && res_hit) begin
        accept    = 1'b1;
        state_nxt = HELD;
      end
      HELD: if (scan_end && stable_now && !res_hit) begin
        release_key = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'h0;
      row_sync <= 4'h0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_hit   <= 1'b0;
      scan_code  <= 4'h0;
      prev_hit   <= 1'b0;
      prev_code  <= 4'h0;
      stable_cnt <= '0;
    end else if (scan_end) begin
      scan_hit   <= 1'b0;
      scan_code  <= 4'h0;
      prev_hit   <= res_hit;
      prev_code  <= res_code;
      stable_cnt <= cnt_nxt;
    end else if (sample && col_hit && !scan_hit) begin
      scan_hit  <= 1'b1;
      scan_code <= col_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= res_code;
        key_down <= 1'b1;
      end else if (release_key) begin
        key_down <= 1'b0;
      end
    end
  end

  // Clear takes priority but a coincident strobe still lands as the first digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits      <= 32'h0;
      digit_count <= 4'd0;
    end else if (clear && key_valid) begin
      digits      <= {28'h0, key_code};
      digit_count <= 4'd1;
    end else if (clear) begin
      digits      <= 32'h0;
      digit_count <= 4'd0;
    end else if (key_valid) begin
      digits      <= {digits[27:0], key_code};
      digit_count <= (digit_count == 4'd8) ? 4'd8 : digit_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: scan-level keypad model driven with per-scan key sets, compared every clock.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [31:0] digits;
  logic [3:0]  digit_count;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .reset(reset), .row(row), .clear(clear), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .digits(digits), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  // Physical keypad: bit r*4+c pressed shorts row r to column c.
  logic [15:0] pressed;
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model
  int          keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int          m_prev, m_cnt, m_count;
  bit          m_held, exp_valid;
  logic [3:0]  m_code;
  logic [31:0] m_digits;
  int          pulse_seen;

  task automatic model_reset();
    m_prev = -1; m_cnt = 0; m_held = 0; exp_valid = 0;
    m_code = 4'h0; m_digits = 32'h0; m_count = 0;
  endtask

  function automatic int scan_result(input logic [15:0] keys);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*4+c]) return keymap[r*4+c];
    return -1;
  endfunction

  task automatic model_scan_end(input logic [15:0] keys);
    int res;
    res = scan_result(keys);
    if (res == m_prev) m_cnt = (m_cnt < DEB) ? m_cnt + 1 : DEB;
    else begin
      m_cnt  = 1;
      m_prev = res;
    end
    if (!m_held && m_cnt == DEB && res >= 0) begin
      exp_valid = 1;
      m_code    = 4'(res);
      m_held    = 1;
    end else if (m_held && m_cnt == DEB && res < 0) begin
      m_held = 0;
    end
  endtask

  task automatic check_all(input int i);
    logic [3:0] one;
    logic [3:0] exp_col;
    one     = 4'b0001;
    exp_col = ~(one << ((i / SCAN_DIV) % 4));
    check("col", {28'h0, col}, {28'h0, exp_col});
    check("key_valid", {31'h0, key_valid}, {31'h0, exp_valid});
    check("key_down", {31'h0, key_down}, {31'h0, m_held});
    check("key_code", {28'h0, key_code}, {28'h0, m_code});
    check("digits", digits, m_digits);
    check("digit_count", {28'h0, digit_count}, 32'(m_count));
  endtask

  // One full scan period with a fixed key set; clear is high in the cycle before edge clr_at.
  task automatic run_scan(input logic [15:0] keys, input int clr_at);
    pressed = keys;
    for (int i = 1; i <= 4 * SCAN_DIV; i++) begin
      clear = (i == clr_at);
      @(posedge clk);
      #1;
      if (clear) begin
        m_digits = 32'h0;
        m_count  = 0;
      end
      if (exp_valid) begin
        m_digits = {m_digits[27:0], m_code};
        m_count  = (m_count < 8) ? m_count + 1 : 8;
      end
      exp_valid = 0;
      if (i == 4 * SCAN_DIV) model_scan_end(keys);
      check_all(i);
      if (key_valid) pulse_seen++;
    end
    clear = 1'b0;
  endtask

  task automatic scans(input logic [15:0] keys, input int n);
    for (int k = 0; k < n; k++) run_scan(keys, 0);
  endtask

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] one16;
    one16 = 16'h1;
    return one16 << (r * 4 + c);
  endfunction

  // Key bit for a hex digit 1..9 on the numeric block.
  function automatic logic [15:0] digit_key(input int d);
    return kbit((d - 1) / 3, (d - 1) % 3);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_col", {28'h0, col}, 32'hE);
    check("rst_outs", {key_code, key_valid, key_down, digit_count}, 32'h0);
    check("rst_digits", digits, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [15:0] rkeys;

  initial begin
    reset = 1'b0; clear = 1'b0; pressed = 16'h0; pulse_seen = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_col", {28'h0, col}, 32'hE);
      check("rst_outs", {key_code, key_valid, key_down, digit_count}, 32'h0);
      check("rst_digits", digits, 32'h0);
    end
    reset = 1'b1;

    // Free run, then '5' held 10 scans.
    scans(16'h0, 2);
    pulse_seen = 0;
    scans(kbit(1, 1), 10);
    check("p5_pulses", 32'(pulse_seen), 1);
    check("p5_digits", digits, 32'h00000005);
    scans(16'h0, 4);

    // Bouncy 'A' press and bouncy release.
    pulse_seen = 0;
    for (int k = 0; k < 2; k++) begin
      run_scan(kbit(0, 3), 0);
      run_scan(16'h0, 0);
    end
    check("bounce_no_strobe", 32'(pulse_seen), 0);
    scans(kbit(0, 3), 5);
    check("bounce_one_strobe", 32'(pulse_seen), 1);
    for (int k = 0; k < 2; k++) begin
      run_scan(16'h0, 0);
      run_scan(kbit(0, 3), 0);
    end
    scans(16'h0, 2);
    check("release_pending", {31'h0, key_down}, 32'h1);
    scans(16'h0, 1);
    check("release_done", {31'h0, key_down}, 32'h0);

    // Nine digits saturate the register.
    for (int d = 1; d <= 9; d++) begin
      scans(digit_key(d), 3);
      scans(16'h0, 3);
    end
    check("nine_digits", digits, 32'h23456789);
    check("nine_count", {28'h0, digit_count}, 32'h8);

    // Second key while held, then both from the start.
    pulse_seen = 0;
    scans(kbit(0, 0), 4);
    scans(kbit(0, 0) | kbit(3, 3), 4);
    scans(16'h0, 4);
    scans(kbit(0, 0) | kbit(3, 3), 4);
    check("two_key_code", {28'h0, key_code}, 32'h1);
    scans(16'h0, 4);
    check("two_key_pulses", 32'(pulse_seen), 2);

    // Clear coincident with the 'E' strobe.
    for (int d = 1; d <= 8; d++) begin
      scans(digit_key(d), 3);
      scans(16'h0, 3);
    end
    check("pre_clear", digits, 32'h12345678);
    scans(kbit(3, 2), 3);
    run_scan(kbit(3, 2), 1);
    check("clear_strobe_digits", digits, 32'h0000000E);
    check("clear_strobe_count", {28'h0, digit_count}, 32'h1);
    scans(16'h0, 4);

    // Reset mid-debounce with the key still held.
    pulse_seen = 0;
    scans(kbit(1, 1), 2);
    do_reset();
    scans(kbit(1, 1), 2);
    check("rst_no_strobe", 32'(pulse_seen), 0);
    scans(kbit(1, 1), 1);
    check("rst_fresh_strobe", 32'(pulse_seen), 1);
    scans(16'h0, 4);

    // Random key sets per scan with occasional clear.
    rkeys = 16'h0;
    for (int s = 0; s < 200; s++) begin
      int sel;
      int clr_at;
      sel = $urandom_range(0, 9);
      if (sel <= 2)      rkeys = 16'h0;
      else if (sel <= 5) rkeys = rkeys;
      else if (sel <= 8) rkeys = kbit($urandom_range(0, 3), $urandom_range(0, 3));
      else               rkeys = kbit($urandom_range(0, 3), $urandom_range(0, 3)) |
                                 kbit($urandom_range(0, 3), $urandom_range(0, 3));
      clr_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4 * SCAN_DIV) : 0;
      run_scan(rkeys, clr_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
